// File: rtl/me_wb_skid.sv
// me_wb_skid: MEM->WB pipeline register with valid/ready handshake, synchronous
// flush and a one-entry skid buffer so WB stalls never reach MEM combinationally.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous flush, drops held and incoming entries
//   me_valid / me_ready   upstream handshake (me_ready is registered)
//   me_*                  incoming payload {select, writeReg, outMem, outAlu, rd}
//   wb_valid / wb_ready   downstream handshake (wb_valid is registered)
//   wb_*                  held payload; wb_writeReg is 0 whenever wb_valid is 0
//   wb_result             (WB_RESULT_EN only) registered select ? outMem : outAlu
//
// Optional feature macro: WB_RESULT_EN adds the wb_result output.

module me_wb_skid #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  me_valid,
    output logic                  me_ready,
    input  logic                  me_aluOut_WB_memOut,
    input  logic                  me_writeReg,
    input  logic [DATA_W-1:0]     me_outMem,
    input  logic [DATA_W-1:0]     me_outAlu,
    input  logic [REG_ADDR_W-1:0] me_rd,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  wb_aluOut_WB_memOut,
    output logic                  wb_writeReg,
    output logic [DATA_W-1:0]     wb_outMem,
    output logic [DATA_W-1:0]     wb_outAlu,
    output logic [REG_ADDR_W-1:0] wb_rd
`ifdef WB_RESULT_EN
    ,
    output logic [DATA_W-1:0]     wb_result
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                  wb_valid_q, wb_valid_d;
    logic                  me_ready_q, me_ready_d;
    logic                  out_sel_q,  out_sel_d;
    logic                  out_we_q,   out_we_d;
    logic [DATA_W-1:0]     out_mem_q,  out_mem_d;
    logic [DATA_W-1:0]     out_alu_q,  out_alu_d;
    logic [REG_ADDR_W-1:0] out_rd_q,   out_rd_d;
    logic                  skid_sel_q, skid_sel_d;
    logic                  skid_we_q,  skid_we_d;
    logic [DATA_W-1:0]     skid_mem_q, skid_mem_d;
    logic [DATA_W-1:0]     skid_alu_q, skid_alu_d;
    logic [REG_ADDR_W-1:0] skid_rd_q,  skid_rd_d;
`ifdef WB_RESULT_EN
    logic [DATA_W-1:0]     result_q,   result_d;
`endif

    logic accept_c;
    logic consume_c;
    logic in_we_c;

    assign accept_c  = me_valid & me_ready_q;
    assign consume_c = wb_valid_q & wb_ready;
    // Writes to register 0 are squashed at capture time.
    assign in_we_c   = me_writeReg & (me_rd != REG_ADDR_W'(0));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush dominates everything
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept_c) state_d = S_FULL;
                S_FULL: begin
                    if (accept_c && !consume_c)      state_d = S_SKID;
                    else if (!accept_c && consume_c) state_d = S_EMPTY;
                end
                S_SKID:  if (consume_c) state_d = S_FULL;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        wb_valid_d = (state_d != S_EMPTY);
        me_ready_d = (state_d != S_SKID);
        out_sel_d  = out_sel_q;
        out_we_d   = out_we_q;
        out_mem_d  = out_mem_q;
        out_alu_d  = out_alu_q;
        out_rd_d   = out_rd_q;
        skid_sel_d = skid_sel_q;
        skid_we_d  = skid_we_q;
        skid_mem_d = skid_mem_q;
        skid_alu_d = skid_alu_q;
        skid_rd_d  = skid_rd_q;
`ifdef WB_RESULT_EN
        result_d   = result_q;
`endif
        if (flush) begin
            out_we_d   = 1'b0;
            skid_sel_d = 1'b0;
            skid_we_d  = 1'b0;
            skid_mem_d = '0;
            skid_alu_d = '0;
            skid_rd_d  = '0;
        end else begin
            case (state_q)
                S_EMPTY, S_FULL: begin
                    if (accept_c && (state_q == S_EMPTY || consume_c)) begin
                        out_sel_d = me_aluOut_WB_memOut;
                        out_we_d  = in_we_c;
                        out_mem_d = me_outMem;
                        out_alu_d = me_outAlu;
                        out_rd_d  = me_rd;
`ifdef WB_RESULT_EN
                        result_d  = me_aluOut_WB_memOut ? me_outMem : me_outAlu;
`endif
                    end else if (accept_c) begin
                        skid_sel_d = me_aluOut_WB_memOut;
                        skid_we_d  = in_we_c;
                        skid_mem_d = me_outMem;
                        skid_alu_d = me_outAlu;
                        skid_rd_d  = me_rd;
                    end else if (consume_c) begin
                        // Stage drains: keep the write enable low while invalid.
                        out_we_d = 1'b0;
                    end
                end
                S_SKID: begin
                    if (consume_c) begin
                        out_sel_d = skid_sel_q;
                        out_we_d  = skid_we_q;
                        out_mem_d = skid_mem_q;
                        out_alu_d = skid_alu_q;
                        out_rd_d  = skid_rd_q;
`ifdef WB_RESULT_EN
                        result_d  = skid_sel_q ? skid_mem_q : skid_alu_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and skid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            me_ready_q <= 1'b1;
            out_sel_q  <= 1'b0;
            out_we_q   <= 1'b0;
            out_mem_q  <= '0;
            out_alu_q  <= '0;
            out_rd_q   <= '0;
            skid_sel_q <= 1'b0;
            skid_we_q  <= 1'b0;
            skid_mem_q <= '0;
            skid_alu_q <= '0;
            skid_rd_q  <= '0;
`ifdef WB_RESULT_EN
            result_q   <= '0;
`endif
        end else begin
            wb_valid_q <= wb_valid_d;
            me_ready_q <= me_ready_d;
            out_sel_q  <= out_sel_d;
            out_we_q   <= out_we_d;
            out_mem_q  <= out_mem_d;
            out_alu_q  <= out_alu_d;
            out_rd_q   <= out_rd_d;
            skid_sel_q <= skid_sel_d;
            skid_we_q  <= skid_we_d;
            skid_mem_q <= skid_mem_d;
            skid_alu_q <= skid_alu_d;
            skid_rd_q  <= skid_rd_d;
`ifdef WB_RESULT_EN
            result_q   <= result_d;
`endif
        end
    end

    assign me_ready            = me_ready_q;
    assign wb_valid            = wb_valid_q;
    assign wb_aluOut_WB_memOut = out_sel_q;
    assign wb_writeReg         = out_we_q;
    assign wb_outMem           = out_mem_q;
    assign wb_outAlu           = out_alu_q;
    assign wb_rd               = out_rd_q;
`ifdef WB_RESULT_EN
    assign wb_result           = result_q;
`endif

endmodule

// File: tb/tb_me_wb_skid.sv
// Testbench for me_wb_skid: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_me_wb_skid;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    typedef struct packed {
        logic          sel;
        logic          we;
        logic [DW-1:0] mem;
        logic [DW-1:0] alu;
        logic [RW-1:0] rd;
    } pkt_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          me_valid;
    logic          me_ready;
    logic          me_sel;
    logic          me_we;
    logic [DW-1:0] me_mem;
    logic [DW-1:0] me_alu;
    logic [RW-1:0] me_rd;
    logic          wb_valid;
    logic          wb_ready;
    logic          wb_sel;
    logic          wb_we;
    logic [DW-1:0] wb_mem;
    logic [DW-1:0] wb_alu;
    logic [RW-1:0] wb_rd;
`ifdef WB_RESULT_EN
    logic [DW-1:0] wb_result;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    me_wb_skid #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush               (flush),
        .me_valid            (me_valid),
        .me_ready            (me_ready),
        .me_aluOut_WB_memOut (me_sel),
        .me_writeReg         (me_we),
        .me_outMem           (me_mem),
        .me_outAlu           (me_alu),
        .me_rd               (me_rd),
        .wb_valid            (wb_valid),
        .wb_ready            (wb_ready),
        .wb_aluOut_WB_memOut (wb_sel),
        .wb_writeReg         (wb_we),
        .wb_outMem           (wb_mem),
        .wb_outAlu           (wb_alu),
        .wb_rd               (wb_rd)
`ifdef WB_RESULT_EN
        ,
        .wb_result           (wb_result)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: in-order queue of at most two entries held by the stage.
    pkt_t m_q[$];
    logic m_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ready = 1'b1;
        end else begin
            logic acc, con;
            pkt_t p;
            acc = me_valid && m_ready;
            con = (m_q.size() > 0) && wb_ready;
            if (flush) begin
                m_q.delete();
                m_ready = 1'b1;
            end else begin
                if (con) void'(m_q.pop_front());
                if (acc) begin
                    p.sel = me_sel;
                    p.we  = me_we && (me_rd != 5'd0);
                    p.mem = me_mem;
                    p.alu = me_alu;
                    p.rd  = me_rd;
                    m_q.push_back(p);
                end
                m_ready = (m_q.size() < 2);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("me_ready", 64'(me_ready), 64'(m_ready));
            chk("wb_valid", 64'(wb_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("wb_sel", 64'(wb_sel), 64'(m_q[0].sel));
                chk("wb_we",  64'(wb_we),  64'(m_q[0].we));
                chk("wb_mem", 64'(wb_mem), 64'(m_q[0].mem));
                chk("wb_alu", 64'(wb_alu), 64'(m_q[0].alu));
                chk("wb_rd",  64'(wb_rd),  64'(m_q[0].rd));
`ifdef WB_RESULT_EN
                chk("wb_result", 64'(wb_result), 64'(m_q[0].sel ? m_q[0].mem : m_q[0].alu));
`endif
            end else begin
                chk("wb_we_idle", 64'(wb_we), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic w,
                         input logic [DW-1:0] m, input logic [DW-1:0] a, input logic [RW-1:0] r);
        me_valid = v;
        me_sel   = s;
        me_we    = w;
        me_mem   = m;
        me_alu   = a;
        me_rd    = r;
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        step();
        // Reset values
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_me_ready", 64'(me_ready), 64'd1);
        chk("rst_wb_we",    64'(wb_we),    64'd0);
        chk("rst_wb_rd",    64'(wb_rd),    64'd0);
        chk("rst_wb_alu",   64'(wb_alu),   64'd0);
        chk("rst_wb_mem",   64'(wb_mem),   64'd0);
        rst_n = 1'b1;
        step();

        // 1: one-cycle latency, then an 8-entry stream at full rate
        wb_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h11, 5'd3);
        step();
        chk("t1_valid", 64'(wb_valid), 64'd1);
        chk("t1_rd",    64'(wb_rd),    64'd3);
        chk("t1_alu",   64'(wb_alu),   64'h11);
        chk("t1_model_depth", 64'(m_q.size()), 64'd1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h100 + 32'(i), 5'(i + 1));
            step();
            chk("t1_stream_alu", 64'(wb_alu), 64'h100 + 64'(i));
            chk("t1_stream_ready", 64'(me_ready), 64'd1);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        chk("t1_drained", 64'(wb_valid), 64'd0);

        // 2: stall fills the skid, then drain A then B in order
        wb_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hA, 5'd4);
        step();
        chk("t2_A_held", 64'(wb_alu), 64'hA);
        chk("t2_ready_full", 64'(me_ready), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hB, 5'd5);
        step();
        chk("t2_ready_skid", 64'(me_ready), 64'd0);
        chk("t2_A_still", 64'(wb_alu), 64'hA);
        chk("t2_model_depth", 64'(m_q.size()), 64'd2);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hC, 5'd6);
        step();
        chk("t2_A_stable", 64'(wb_alu), 64'hA);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        wb_ready = 1'b1;
        step();
        chk("t2_B_out", 64'(wb_alu), 64'hB);
        chk("t2_ready_back", 64'(me_ready), 64'd1);
        step();
        chk("t2_empty", 64'(wb_valid), 64'd0);

        // 3: rd = 0 squashes write enable
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h33, 5'd0);
        step();
        chk("t3_valid", 64'(wb_valid), 64'd1);
        chk("t3_we",    64'(wb_we),    64'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();

        // 4: flush in SKID with a concurrent offer
        wb_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hD1, 5'd6);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hE1, 5'd7);
        step();
        chk("t4_in_skid", 64'(me_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hF1, 5'd8);
        step();
        flush = 1'b0;
        chk("t4_valid", 64'(wb_valid), 64'd0);
        chk("t4_we",    64'(wb_we),    64'd0);
        chk("t4_ready", 64'(me_ready), 64'd1);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        wb_ready = 1'b1;
        step();
        chk("t4_nothing", 64'(wb_valid), 64'd0);
        step();

        // 5: asynchronous reset mid-SKID
        wb_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h77, 32'h66, 5'd9);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h55, 32'h44, 5'd10);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(wb_valid), 64'd0);
        chk("t5_ready", 64'(me_ready), 64'd1);
        chk("t5_rd",    64'(wb_rd),    64'd0);
        chk("t5_alu",   64'(wb_alu),   64'd0);
        chk("t5_mem",   64'(wb_mem),   64'd0);
        chk("t5_sel",   64'(wb_sel),   64'd0);
        step();
        rst_n = 1'b1;
        step();

`ifdef WB_RESULT_EN
        // 6: registered result mux
        wb_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'hA5, 32'h5A, 5'd1);
        step();
        chk("t6_mem", 64'(wb_result), 64'hA5);
        drive(1'b1, 1'b0, 1'b1, 32'hA5, 32'h5A, 5'd1);
        step();
        chk("t6_alu", 64'(wb_result), 64'h5A);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
`endif

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            drive(($urandom_range(0, 99) < 70), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 5'($urandom_range(0, 31)));
            wb_ready = ($urandom_range(0, 99) < 55);
            flush    = ($urandom_range(0, 99) < 3);
            step();
        end
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
